// File: rtl/delay_pkg.sv
// Shared helpers for the variable delay line: width calculation, delay
// clamping and output reset values.
package delay_pkg;

  // Output values presented during reset and whenever no valid sample emerges.
  localparam logic OUT_VALID_RST    = 1'b0;
  localparam logic DATA_OUT_RST_BIT = 1'b0;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Map a requested delay onto the legal range 1..max_d.
  function automatic int unsigned clamp_delay(input int unsigned sel,
                                              input int unsigned max_d);
    if (sel == 0)
      return 1;
    else if (sel > max_d)
      return max_d;
    else
      return sel;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port storage for the delay line.
// Ports: clk; en gates both the write and the registered read;
// waddr/wdata write port; raddr/rdata synchronous read port (read-old-data).
module delay_ram #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Same-address read returns the previous contents; the caller bypasses.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[waddr] <= wdata;
      rdata      <= mem[raddr];
    end
  end

endmodule

// File: rtl/var_delay_line.sv
// Runtime-programmable delay line backed by a circular buffer.
// Ports: clk, reset (sync, active-high), en (clock enable, freezes all state),
// delay_sel (requested delay, clamped to 1..MAX_DELAY), in_valid/data_in
// (input sample), out_valid/data_out (delayed sample, data forced to 0 when
// not valid), primed (buffer holds cur_delay samples under the current delay).
module var_delay_line
  import delay_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned MAX_DELAY  = 64,
  localparam int unsigned DELAY_W    = clog2(MAX_DELAY + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DELAY_W-1:0]    delay_sel,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  primed
);

  localparam int unsigned PTR_W   = clog2(MAX_DELAY);
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

  logic [DELAY_W-1:0] sel_d;
  logic [DELAY_W-1:0] cur_delay;
  logic [DELAY_W-1:0] delay_next;
  logic [DELAY_W-1:0] fill_cnt;
  logic [DELAY_W-1:0] cnt_next;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_addr;
  logic [PTR_W:0]     rd_sum;
  logic [ENTRY_W-1:0] ram_rd;
  logic [ENTRY_W-1:0] byp_q;
  logic [ENTRY_W-1:0] entry;
  logic               byp_sel_q;
  logic               primed_q;
  logic               ram_en;

  assign sel_d  = DELAY_W'(clamp_delay(32'(delay_sel), MAX_DELAY));
  assign ram_en = en & ~reset;

  // Delay change restarts the fill; the sample written on that edge is the first.
  always_comb begin
    delay_next = cur_delay;
    cnt_next   = fill_cnt;
    if (sel_d != cur_delay) begin
      delay_next = sel_d;
      cnt_next   = DELAY_W'(1);
    end else if (fill_cnt != cur_delay) begin
      cnt_next = fill_cnt + DELAY_W'(1);
    end
  end

  // Read address (wr_ptr - D + 1) mod MAX_DELAY; the sum stays below 2*MAX_DELAY.
  always_comb begin
    rd_sum = (PTR_W+1)'(wr_ptr) + (PTR_W+1)'(MAX_DELAY)
             - (PTR_W+1)'(delay_next) + (PTR_W+1)'(1);
    if (rd_sum >= (PTR_W+1)'(MAX_DELAY))
      rd_addr = PTR_W'(rd_sum - (PTR_W+1)'(MAX_DELAY));
    else
      rd_addr = PTR_W'(rd_sum);
  end

  // Pointer, fill state and the D=1 write-first bypass register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      cur_delay <= sel_d;
      primed_q  <= OUT_VALID_RST;
      byp_sel_q <= 1'b0;
      byp_q     <= '0;
    end else if (en) begin
      wr_ptr    <= (wr_ptr == PTR_W'(MAX_DELAY - 1)) ? '0 : wr_ptr + PTR_W'(1);
      fill_cnt  <= cnt_next;
      cur_delay <= delay_next;
      primed_q  <= (cnt_next == delay_next);
      byp_sel_q <= (delay_next == DELAY_W'(1));
      byp_q     <= {in_valid, data_in};
    end
  end

  delay_ram #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (MAX_DELAY),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .waddr (wr_ptr),
    .wdata ({in_valid, data_in}),
    .raddr (rd_addr),
    .rdata (ram_rd)
  );

  // Only entries written under the current delay (primed) may emerge.
  assign entry     = byp_sel_q ? byp_q : ram_rd;
  assign primed    = primed_q;
  assign out_valid = primed_q & entry[DATA_WIDTH];
  assign data_out  = out_valid ? entry[DATA_WIDTH-1:0] : {DATA_WIDTH{DATA_OUT_RST_BIT}};

endmodule
